trigger_driver: RTL

Stimulus source for the triggered-capture block: on a start pulse it emits a programmed sequence of data words, each with a one-cycle trigger, then checks the capture block's confirm flag for each word. It counts sent and mismatched words and pulses done at the end of the sequence. It sits upstream of the capture block: its `trig` and `dout` drive the capture's `trig` and `din`, and the capture's `crfm` returns on `crfm_in`.

---
 rtl/trigger_pkg.sv | 15 +
 rtl/sat_counter.sv | 24 ++
 rtl/trigger_driver.sv | 135 +++++++++++++
 3 files changed

// File: rtl/trigger_pkg.sv
// Shared types and default widths for the trigger driver and its helpers.
package trigger_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_CNT_W  = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_CHECK,
    ST_GAP,
    ST_DONE
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear and enable that sticks at all-ones.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/trigger_driver.sv
// Emits a seed/step word sequence with one-cycle triggers, checks the capture
// block's confirm after each word and keeps sent/error counts.
module trigger_driver
  import trigger_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_words,
  input  logic [DATA_W-1:0] seed,
  input  logic [DATA_W-1:0] step,
  input  logic [3:0]        gap,
  input  logic              crfm_in,
  output logic              trig,
  output logic [DATA_W-1:0] dout,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  sent_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    num_q;
  logic [DATA_W-1:0]   step_q;
  logic [3:0]          gap_q;
  logic [DATA_W-1:0]   word_q, word_d;
  logic [3:0]          gap_cnt_q, gap_cnt_d;
  logic [CNT_W-1:0]    sent_q, sent_d;
  logic                accept;
  logic                err_en;
  logic                trig_d;
  logic [DATA_W-1:0]   dout_d;

  // NOTE: every signal assigned here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    gap_cnt_d = gap_cnt_q;
    sent_d    = sent_q;
    accept    = 1'b0;
    err_en    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          word_d  = seed;
          sent_d  = '0;
          state_d = (num_words == '0) ? ST_DONE : ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        sent_d  = sent_q + 1'b1;
        state_d = ST_CHECK;
      end
      ST_CHECK: begin
        err_en = !crfm_in;
        // sent_q already includes the word just driven.
        if (sent_q == num_q) begin
          state_d = ST_DONE;
        end else begin
          word_d = word_q + step_q;
          if (gap_q == 4'd0) begin
            state_d = ST_DRIVE;
          end else begin
            gap_cnt_d = gap_q;
            state_d   = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt_q <= 4'd1) begin
          state_d = ST_DRIVE;
        end else begin
          gap_cnt_d = gap_cnt_q - 4'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered from the next state so they line up with it.
    trig_d = (state_d == ST_DRIVE);
    dout_d = ((state_d == ST_DRIVE) || (state_d == ST_CHECK)) ? word_d : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      num_q     <= '0;
      step_q    <= '0;
      gap_q     <= '0;
      word_q    <= '0;
      gap_cnt_q <= '0;
      sent_q    <= '0;
      trig      <= 1'b0;
      dout      <= '0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      gap_cnt_q <= gap_cnt_d;
      sent_q    <= sent_d;
      trig      <= trig_d;
      dout      <= dout_d;
      if (accept) begin
        num_q  <= num_words;
        step_q <= step;
        gap_q  <= gap;
      end
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept),
    .en    (err_en),
    .count (err_cnt)
  );

  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign sent_cnt = sent_q;

endmodule
